// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Purpose  : Byte handshake and serial-line status bundle for uart_tx_fifo.
// Revision : 1.0  initial release
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic               tx_valid_i;
    logic [7:0]         tx_data_i;
    logic               tx_ready_o;
    logic               tx_o;
    logic               busy_o;
    logic [c_CNT_W-1:0] fifo_cnt_o;

    modport master (
        output tx_valid_i,
        output tx_data_i,
        input  tx_ready_o,
        input  tx_o,
        input  busy_o,
        input  fifo_cnt_o
    );

    modport slave (
        input  tx_valid_i,
        input  tx_data_i,
        output tx_ready_o,
        output tx_o,
        output busy_o,
        output fifo_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Buffered 8N1 UART transmitter, byte FIFO drained back-to-back.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int BIT_DIV    = 868,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    uart_tx_fifo_if.slave bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int c_DIV_W = $clog2(BIT_DIV);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(BIT_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]         c_STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_cnt;
    state_t             r_state;
    logic [c_DIV_W-1:0] r_div;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic               r_tx;

    logic w_ready;
    logic w_push;
    logic w_nonempty;
    logic w_bit_end;
    logic w_frame_end;
    logic w_pop;

    assign w_ready     = (r_cnt < c_DEPTH);
    assign w_push      = bus.tx_valid_i && w_ready;
    assign w_nonempty  = (r_cnt != '0);
    assign w_bit_end   = (r_div == c_DIV_LAST);
    assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_idx == c_STOP_LAST);
    // Pop either from idle or exactly on the last stop-bit edge, so frames abut.
    assign w_pop       = w_nonempty && ((r_state == S_IDLE) || w_frame_end);

    always_ff @(posedge clk_i) begin
        if (w_push && !rst_i) begin
            r_mem[r_wr_ptr] <= bus.tx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_div   <= '0;
                        r_idx   <= '0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_div   <= '0;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_div <= '0;
                        if (r_idx == 3'd7) begin
                            r_idx   <= '0;
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            r_tx  <= r_shift[r_idx + 3'd1];
                        end
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_div <= '0;
                        if (r_idx == c_STOP_LAST) begin
                            r_idx <= '0;
                            if (w_pop) begin
                                r_shift <= r_mem[r_rd_ptr];
                                r_tx    <= 1'b0;
                                r_state <= S_START;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready_o = w_ready;
    assign bus.tx_o       = r_tx;
    assign bus.busy_o     = (r_state != S_IDLE) || w_nonempty;
    assign bus.fifo_cnt_o = r_cnt;
endmodule
`default_nettype wire
